// File: rtl/instr_loader.sv
// LEGv8 instruction loader: packs decoded field beats into instruction words
// and writes them to instruction memory, range-checking every immediate.
module instr_loader #(
    parameter int          ADDR_W    = 6,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rn,
    input  logic [63:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [ADDR_W-1:0] BASE      = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE  = 1;
    localparam logic [ADDR_W:0]   CNT_ONE   = 1;

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_word;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W:0]   r_count;
    logic [1:0]        r_code;
    logic [31:0]       w_word;
    logic              w_fits;
    logic              w_fits9;
    logic              w_fits12;
    logic              w_fits19;

    // A W-bit field fits when every bit from W-1 upward is a sign copy.
    assign w_fits9  = (&in_imm[63:8])  | ~(|in_imm[63:8]);
    assign w_fits12 = (&in_imm[63:11]) | ~(|in_imm[63:11]);
    assign w_fits19 = (&in_imm[63:18]) | ~(|in_imm[63:18]);

    always_comb begin
        w_word = '0;
        w_fits = 1'b0;
        unique case (in_op)
            2'b00: begin
                w_fits = w_fits9;
                w_word = {11'b11111000010, in_imm[8:0], 2'b00, in_rn, in_rt};
            end
            2'b01: begin
                w_fits = w_fits9;
                w_word = {11'b11111000000, in_imm[8:0], 2'b00, in_rn, in_rt};
            end
            2'b10: begin
                w_fits = w_fits19;
                w_word = {8'b10110100, in_imm[18:0], in_rt};
            end
            2'b11: begin
                w_fits = w_fits12;
                w_word = {10'b1001000100, in_imm[11:0], in_rn, in_rt};
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                if (in_valid) begin
                    w_next = w_fits ? S_WRITE : S_ERROR;
                end
            end
            S_WRITE: begin
                if (r_last) begin
                    w_next = S_DONE;
                end else if (r_addr == LAST_ADDR) begin
                    w_next = S_ERROR;
                end else begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word  <= '0;
            r_last  <= 1'b0;
            r_addr  <= BASE;
            r_count <= '0;
            r_code  <= 2'b00;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_addr  <= BASE;
                        r_count <= '0;
                        r_code  <= 2'b00;
                    end
                end
                S_RUN: begin
                    if (in_valid) begin
                        if (w_fits) begin
                            r_word <= w_word;
                            r_last <= in_last;
                        end else begin
                            r_code <= 2'b01;
                        end
                    end
                end
                S_WRITE: begin
                    r_count <= r_count + CNT_ONE;
                    // A full memory stops the session without wrapping the address.
                    if (!r_last) begin
                        if (r_addr == LAST_ADDR) begin
                            r_code <= 2'b10;
                        end else begin
                            r_addr <= r_addr + ADDR_ONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_RUN);
    assign busy      = (r_state == S_RUN) | (r_state == S_WRITE);
    assign mem_we    = (r_state == S_WRITE);
    assign done      = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_word;
    assign err_code  = r_code;
    assign count     = r_count;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized and directed bench for instr_loader against a transaction-level
// model that encodes words with plain arithmetic.
module tb_instr_loader;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_last  = 1'b0;
    logic [1:0]    in_op    = '0;
    logic [4:0]    in_rt    = '0;
    logic [4:0]    in_rn    = '0;
    logic [63:0]   in_imm   = '0;
    logic          in_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [1:0]    err_code;
    logic [AW:0]   count;

    instr_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rt(in_rt), .in_rn(in_rn),
        .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err),
        .err_code(err_code), .count(count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic int fwidth(input logic [1:0] op);
        case (op)
            2'b10:   return 19;
            2'b11:   return 12;
            default: return 9;
        endcase
    endfunction

    function automatic bit fits(input logic [1:0] op, input logic [63:0] imm);
        longint lim;
        longint v;
        lim = longint'(1) <<< (fwidth(op) - 1);
        v   = $signed(imm);
        return (v >= -lim) && (v < lim);
    endfunction

    function automatic logic [31:0] enc(input logic [1:0] op,
                                        input logic [4:0] rt,
                                        input logic [4:0] rn,
                                        input logic [63:0] imm);
        longint f;
        longint r;
        f = $signed(imm) & ((longint'(1) <<< fwidth(op)) - 1);
        case (op)
            2'b00:   r = 64'hF840_0000 + f * 4096 + rn * 32 + rt;
            2'b01:   r = 64'hF800_0000 + f * 4096 + rn * 32 + rt;
            2'b10:   r = 64'hB400_0000 + f * 32 + rt;
            default: r = 64'h9100_0000 + f * 1024 + rn * 32 + rt;
        endcase
        return r[31:0];
    endfunction

    // Session model: flags for accepting, writing and the two end conditions.
    bit          m_run, m_wr, m_done, m_err, m_last;
    int          m_code, m_count, m_addr;
    logic [31:0] m_word = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run = 0; m_wr = 0; m_done = 0; m_err = 0; m_last = 0;
            m_code = 0; m_count = 0; m_addr = 0; m_word = '0;
        end else if (m_wr) begin
            m_wr = 0;
            m_count++;
            if (m_last) m_done = 1;
            else if (m_addr == DEPTH - 1) begin m_err = 1; m_code = 2; end
            else begin m_addr++; m_run = 1; end
        end else if (m_run) begin
            if (in_valid) begin
                m_run = 0;
                if (fits(in_op, in_imm)) begin
                    m_word = enc(in_op, in_rt, in_rn, in_imm);
                    m_last = in_last;
                    m_wr   = 1;
                end else begin
                    m_err = 1; m_code = 1;
                end
            end
        end else if (start) begin
            m_run = 1; m_done = 0; m_err = 0;
            m_code = 0; m_count = 0; m_addr = 0;
        end
    end

    typedef struct {
        int          a;
        logic [31:0] d;
    } wr_t;
    wr_t wlog[$];

    always @(negedge clk) begin
        chk("in_ready", in_ready, m_run);
        chk("busy", busy, m_run | m_wr);
        chk("mem_we", mem_we, m_wr);
        chk("done", done, m_done);
        chk("err", err, m_err);
        chk("err_code", err_code, m_code);
        chk("count", count, m_count);
        chk("mem_addr", mem_addr, m_addr);
        if (m_wr || reset) chk("mem_wdata", mem_wdata, m_word);
        if (mem_we === 1'b1) wlog.push_back('{a: int'(mem_addr), d: mem_wdata});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] op, input logic [4:0] rt,
                        input logic [4:0] rn, input longint imm,
                        input bit last, input int maxw, output bit acc);
        in_op = op; in_rt = rt; in_rn = rn; in_imm = imm;
        in_last = last; in_valid = 1'b1; acc = 0;
        for (int i = 0; i < maxw && !acc; i++) begin
            acc = m_run;
            tick();
        end
        in_valid = 1'b0;
    endtask

    function automatic longint gen_imm(input logic [1:0] op);
        longint lim;
        lim = longint'(1) <<< (fwidth(op) - 1);
        case ($urandom % 8)
            0:       return lim - 1;
            1:       return -lim;
            2:       return lim;
            3:       return -lim - 1;
            4:       return longint'({$urandom, $urandom});
            default: return longint'($urandom_range(0, 32'(2 * lim - 1))) - lim;
        endcase
    endfunction

    bit acc;
    int n0;

    initial begin
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);

        // single LDUR
        pulse_start();
        send(2'b00, 5'd1, 5'd2, -8, 1, 4, acc);
        chk("t1_acc", acc, 1);
        chk("t1_we", mem_we, 1);
        chk("t1_addr", mem_addr, 0);
        chk("t1_data", mem_wdata, 32'hF85F8041);
        tick();
        chk("t1_done", done, 1);
        chk("t1_count", count, 1);
        chk("t1_busy", busy, 0);

        // ADDI then CBZ
        pulse_start();
        n0 = wlog.size();
        send(2'b11, 5'd3, 5'd4, 5, 0, 4, acc);
        send(2'b10, 5'd7, 5'd0, -2, 1, 4, acc);
        tick();
        chk("t2_nwr", wlog.size(), n0 + 2);
        if (wlog.size() >= n0 + 2) begin
            chk("t2_a0", wlog[n0].a, 0);
            chk("t2_d0", wlog[n0].d, 32'h91001483);
            chk("t2_a1", wlog[n0+1].a, 1);
            chk("t2_d1", wlog[n0+1].d, 32'hB4FFFFC7);
        end
        chk("t2_count", count, 2);
        chk("t2_done", done, 1);

        // immediate range boundaries
        pulse_start();
        send(2'b01, 5'd5, 5'd6, 255, 1, 4, acc);
        tick();
        chk("t3_stur255", wlog[$].d, 32'hF80FF0C5);
        pulse_start();
        n0 = wlog.size();
        send(2'b01, 5'd5, 5'd6, 256, 1, 4, acc);
        tick();
        chk("t3_err", err, 1);
        chk("t3_code", err_code, 1);
        chk("t3_addr", mem_addr, 0);
        chk("t3_nowr", wlog.size(), n0);
        pulse_start();
        send(2'b00, 5'd0, 5'd0, -256, 1, 4, acc);
        tick();
        chk("t3_ldur_m256", wlog[$].d, 32'hF8500000);
        chk("t3_done", done, 1);
        pulse_start();
        send(2'b00, 5'd0, 5'd0, -257, 1, 4, acc);
        tick();
        chk("t3_ldur_m257", err_code, 1);

        // memory full
        pulse_start();
        n0 = wlog.size();
        for (int i = 0; i < 4; i++) begin
            send(2'b11, 5'(i), 5'(i), longint'(i * 10), 0, 4, acc);
            chk("t4_acc", acc, 1);
        end
        send(2'b11, 5'd9, 5'd9, 1, 0, 6, acc);
        chk("t4_fifth", acc, 0);
        chk("t4_err", err, 1);
        chk("t4_code", err_code, 2);
        chk("t4_count", count, 4);
        chk("t4_nwr", wlog.size(), n0 + 4);
        for (int i = 0; i < 4 && n0 + i < wlog.size(); i++)
            chk("t4_addr", wlog[n0+i].a, i);

        // reset during WRITE
        pulse_start();
        send(2'b00, 5'd1, 5'd1, 0, 0, 4, acc);
        chk("t5_we", mem_we, 1);
        #2 reset = 1'b1;
        #1;
        chk("t5_rst_we", mem_we, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_cnt", count, 0);
        chk("t5_rst_wd", mem_wdata, 0);
        tick(); tick();
        reset = 1'b0;
        pulse_start();
        send(2'b11, 5'd1, 5'd1, 7, 1, 4, acc);
        tick();
        chk("t5_restart_addr", wlog[$].a, 0);

        // idle in RUN, start ignored
        pulse_start();
        n0 = wlog.size();
        for (int i = 0; i < 10; i++) begin
            chk("t6_ready", in_ready, 1);
            tick();
        end
        chk("t6_nowr", wlog.size(), n0);
        send(2'b11, 5'd2, 5'd2, 2, 0, 4, acc);
        tick();
        pulse_start();
        chk("t6_count", count, 1);
        chk("t6_addr", mem_addr, 1);
        send(2'b11, 5'd2, 5'd2, 3, 1, 4, acc);
        tick();
        chk("t6_addr2", wlog[$].a, 1);
        chk("t6_done", done, 1);

        // random sessions
        for (int s = 0; s < 60; s++) begin
            int beats;
            logic [1:0] op;
            pulse_start();
            beats = 0;
            while (m_run && beats < 8) begin
                repeat ($urandom % 3) tick();
                op = 2'($urandom);
                send(op, 5'($urandom), 5'($urandom), gen_imm(op),
                     ($urandom % 4 == 0) || beats == 7, 4, acc);
                chk("rnd_acc", acc, 1);
                tick();
                beats++;
            end
            in_valid = 1'($urandom);
            tick();
            in_valid = 1'b0;
        end

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
- Writes LEGv8 instruction words into instruction memory from a stream of decoded fields; used for test and boot program loading.
- Packs each immediate back into its instruction field, performing the inverse of the datapath sign extender.
- Each immediate is range-checked as a signed value for its field width, so a loaded word sign-extends back to the original operand.
- Handles one word per two cycles. Stops on the last beat, on a range error, or when memory is full.

Parameters:
- ADDR_W, 6: word-address width of instruction memory (capacity 2^ADDR_W words).
- BASE_ADDR, 0: first word address written after start.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load session.
- in_valid  input  1  field beat valid.
- in_ready  output  1  block can accept a beat.
- in_op  input  2  instruction select: 00 LDUR, 01 STUR, 10 CBZ, 11 ADDI.
- in_rt  input  5  Rt (LDUR/STUR/CBZ) or Rd (ADDI).
- in_rn  input  5  Rn; ignored for CBZ.
- in_imm  input  64  signed immediate (byte or word offset as used by the datapath).
- in_last  input  1  marks the final beat of the session.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_W  word address.
- mem_wdata  output  32  encoded instruction.
- busy  output  1  session active.
- done  output  1  session ended normally; held until the next start.
- err  output  1  session aborted; held until the next start.
- err_code  output  2  01 immediate out of range, 10 memory full, 00 none.
- count  output  ADDR_W+1  words written this session.

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs 0; mem_addr = BASE_ADDR. A reset mid-session drops mem_we at once and discards the pending word.
- States: IDLE, RUN, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - go to RUN;
  - clear done, err, err_code and count;
  - set mem_addr = BASE_ADDR.
- start during RUN/WRITE is ignored.
- RUN: in_ready = 1, busy = 1. An accepted beat (in_valid & in_ready) is range-checked:
  - If the immediate fits, encode the word into a register and go to WRITE.
  - If it does not fit, go to ERROR with err_code = 01. Nothing is written and mem_addr is unchanged, so it points at the failing slot.
- WRITE: in_ready = 0. mem_we = 1 for exactly one cycle with the registered word, so latency is beat accepted at cycle N -> mem_we at N+1. On exit, count increments and:
  - if the beat was last, go to DONE (done = 1);
  - else if mem_addr equals 2^ADDR_W-1, go to ERROR with err_code = 10 (the word is written; mem_addr does not wrap);
  - else mem_addr increments and the state returns to RUN.
- DONE/ERROR: busy = 0, in_ready = 0; the state is held until start.
- Encoding (bit ranges inclusive):
  - LDUR: [31:21] = 11111000010, [20:12] = imm[8:0], [11:10] = 00, [9:5] = Rn, [4:0] = Rt.
  - STUR: same layout with [31:21] = 11111000000.
  - CBZ: [31:24] = 10110100, [23:5] = imm[18:0], [4:0] = Rt.
  - ADDI: [31:22] = 1001000100, [21:10] = imm[11:0], [9:5] = Rn, [4:0] = Rd.
- Range rule: a field of width W fits when in_imm[63:W-1] are all equal. W is 9 for LDUR/STUR, 19 for CBZ and 12 for ADDI.
- Accepted ranges: LDUR/STUR -256..255, CBZ -262144..262143, ADDI -2048..2047. The field is always in_imm[W-1:0].
- in_ready is a function of state only, not of in_valid.

Test Plan:
- start; LDUR Rt=1, Rn=2, imm=-8, last=1 -> one cycle after acceptance: mem_we=1, mem_addr=0, mem_wdata=0xF85F8041. Then done=1, count=1, busy=0.
- start; ADDI Rd=3, Rn=4, imm=5; then CBZ Rt=7, imm=-2, last=1 -> writes 0x91001483 at addr 0 and 0xB4FFFFC7 at addr 1; count=2, done=1.
- STUR boundaries: imm=255 -> word 0xF80FF0C5 written. Next session, imm=256 -> no mem_we, err=1, err_code=01, mem_addr=0. Also check LDUR imm=-256 accepted and imm=-257 rejected.
- ADDR_W=2, five non-last beats -> four writes at addr 0..3, then err=1, err_code=10, count=4. The fifth beat is never accepted (in_ready=0).
- Assert reset while in WRITE -> mem_we=0 in the same cycle, and all outputs read 0 while reset is high. After reset falls and a start is issued, addr restarts at BASE_ADDR.
- Hold in_valid=0 in RUN for 10 cycles -> in_ready stays 1 and no writes occur. A start pulse during RUN leaves count and addr unchanged.
